// File: rtl/pl_imem_arb_if.sv
// Instruction-memory arbiter bus: CPU fetch port, program-loader write port and memory port.
interface pl_imem_arb_if #(
    parameter int AW = 6
);
    logic          f_req;
    logic [31:0]   f_addr;
    logic          f_stall;
    logic          f_valid;
    logic [31:0]   f_inst;
    logic          l_req;
    logic [31:0]   l_addr;
    logic [31:0]   l_data;
    logic          l_ack;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [31:0]   m_rdata;

    // Arbiter side
    modport slave (
        input  f_req, f_addr, l_req, l_addr, l_data, m_rdata,
        output f_stall, f_valid, f_inst, l_ack, m_we, m_addr, m_wdata
    );

    // Requester/memory side
    modport master (
        output f_req, f_addr, l_req, l_addr, l_data, m_rdata,
        input  f_stall, f_valid, f_inst, l_ack, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/pl_imem_arb.sv
// Single-port imem arbiter: loader wins contention until fetch has starved MAXWAIT grants.
// Grant is combinational (0 cycles); fetch data returns 1 cycle after grant; losers see f_stall / no l_ack.
module pl_imem_arb #(
    parameter int AW      = 6,
    parameter int MAXWAIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    pl_imem_arb_if.slave   bus
);
    localparam int SW = (MAXWAIT < 1) ? 1 : $clog2(MAXWAIT + 1);
    localparam logic [SW-1:0] SMAX = SW'(MAXWAIT);

    logic          gnt_f;
    logic          gnt_l;
    logic [SW-1:0] starve;
    logic          pend;
    logic [31:0]   inst_q;

    // Reset gates the grant so no write or ack can leak out while rst is high.
    always_comb begin
        gnt_f = 1'b0;
        gnt_l = 1'b0;
        if (!rst) begin
            gnt_f = bus.f_req && (!bus.l_req || (starve == SMAX));
            gnt_l = bus.l_req && !gnt_f;
        end
    end

    always_comb begin
        bus.m_we    = gnt_l;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        if (gnt_f) begin
            bus.m_addr = bus.f_addr[AW+1:2];
        end else if (gnt_l) begin
            bus.m_addr  = bus.l_addr[AW+1:2];
            bus.m_wdata = bus.l_data;
        end
    end

    assign bus.l_ack   = gnt_l;
    assign bus.f_stall = bus.f_req && !gnt_f;
    assign bus.f_valid = pend;
    // Live memory data in the return cycle, held copy afterwards.
    assign bus.f_inst  = pend ? bus.m_rdata : inst_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve <= '0;
            pend   <= 1'b0;
            inst_q <= '0;
        end else begin
            pend <= gnt_f;
            if (pend) begin
                inst_q <= bus.m_rdata;
            end
            if (!bus.f_req || gnt_f) begin
                starve <= '0;
            end else if (gnt_l && (starve != SMAX)) begin
                starve <= starve + 1'b1;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{bus.f_addr[31:AW+2], bus.f_addr[1:0],
                           bus.l_addr[31:AW+2], bus.l_addr[1:0]};
endmodule

// File: tb/tb_pl_imem_arb.sv
// Directed bench for pl_imem_arb with a behavioural 64-word synchronous-read memory.
module tb_pl_imem_arb;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;
    logic exp_f;
    logic prev_f;

    pl_imem_arb_if #(.AW(6)) bus ();

    pl_imem_arb #(.AW(6), .MAXWAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    bit [31:0] mem [64];
    bit        wr  [64];

    function automatic logic [31:0] init_word(input logic [5:0] a);
        return 32'hA500_0000 | {26'b0, a};
    endfunction

    always @(posedge clk) begin
        if (bus.m_we) begin
            mem[bus.m_addr] <= bus.m_wdata;
            wr[bus.m_addr]  <= 1'b1;
        end
        bus.m_rdata <= wr[bus.m_addr] ? mem[bus.m_addr] : init_word(bus.m_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.f_req = 1'b0; bus.f_addr = '0;
        bus.l_req = 1'b0; bus.l_addr = '0; bus.l_data = '0;
        #2;
        chk("rst_fvalid", bus.f_valid, 0);
        chk("rst_finst", bus.f_inst, 0);
        chk("rst_lack", bus.l_ack, 0);
        chk("rst_mwe", bus.m_we, 0);
        bus.l_req = 1'b1; bus.f_req = 1'b1;
        #1;
        chk("rst_lack_req", bus.l_ack, 0);
        chk("rst_mwe_req", bus.m_we, 0);
        bus.l_req = 1'b0; bus.f_req = 1'b0;
        @(negedge clk); rst = 1'b0;

        // Fetch only, back to back
        @(negedge clk);
        bus.f_req = 1'b1; bus.f_addr = 32'h00; #1;
        chk("f0_stall", bus.f_stall, 0);
        chk("f0_maddr", bus.m_addr, 0);
        chk("f0_mwe", bus.m_we, 0);
        @(negedge clk);
        chk("f0_valid", bus.f_valid, 1);
        chk("f0_inst", bus.f_inst, 32'hA500_0000);
        bus.f_addr = 32'h04; #1;
        chk("f1_maddr", bus.m_addr, 1);
        chk("f1_stall", bus.f_stall, 0);
        @(negedge clk);
        chk("f1_valid", bus.f_valid, 1);
        chk("f1_inst", bus.f_inst, 32'hA500_0001);
        bus.f_addr = 32'h08; #1;
        chk("f2_stall", bus.f_stall, 0);
        @(negedge clk);
        chk("f2_valid", bus.f_valid, 1);
        chk("f2_inst", bus.f_inst, 32'hA500_0002);
        bus.f_req = 1'b0; #1;
        chk("idle_stall", bus.f_stall, 0);
        @(negedge clk);
        chk("hold_valid", bus.f_valid, 0);
        chk("hold_inst", bus.f_inst, 32'hA500_0002);

        // Load then fetch the same word
        bus.l_req = 1'b1; bus.l_addr = 32'h6c; bus.l_data = 32'h3c01_0000; #1;
        chk("ld_ack", bus.l_ack, 1);
        chk("ld_mwe", bus.m_we, 1);
        chk("ld_maddr", bus.m_addr, 27);
        chk("ld_wdata", bus.m_wdata, 32'h3c01_0000);
        @(negedge clk);
        bus.l_req = 1'b0; bus.f_req = 1'b1; bus.f_addr = 32'h6c; #1;
        chk("lf_ack", bus.l_ack, 0);
        chk("lf_maddr", bus.m_addr, 27);
        chk("lf_mwe", bus.m_we, 0);
        @(negedge clk);
        chk("lf_valid", bus.f_valid, 1);
        chk("lf_inst", bus.f_inst, 32'h3c01_0000);
        bus.f_req = 1'b0;

        // Contention with MAXWAIT=4: L,L,L,L,F,L,L,L,L,F
        prev_f = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("ct_fvalid", bus.f_valid, prev_f);
            bus.f_req = 1'b1; bus.f_addr = 32'h20;
            bus.l_req = 1'b1; bus.l_addr = 32'h40 + 32'(i) * 4; bus.l_data = 32'(i);
            #1;
            exp_f = (i == 4) || (i == 9);
            chk("ct_lack", bus.l_ack, !exp_f);
            chk("ct_stall", bus.f_stall, !exp_f);
            chk("ct_mwe", bus.m_we, !exp_f);
            prev_f = exp_f;
        end
        @(negedge clk);
        chk("ct_last_valid", bus.f_valid, 1);
        chk("ct_last_inst", bus.f_inst, 32'hA500_0008);
        bus.l_req = 1'b0; bus.f_req = 1'b0;

        // Address wrap and low-bit masking
        @(negedge clk);
        bus.f_req = 1'b1; bus.f_addr = 32'h104; #1;
        chk("wrap_104", bus.m_addr, 1);
        @(negedge clk);
        chk("wrap_inst", bus.f_inst, 32'hA500_0001);
        bus.f_addr = 32'h07; #1;
        chk("wrap_07", bus.m_addr, 1);
        @(negedge clk);
        chk("wrap07_inst", bus.f_inst, 32'hA500_0001);
        bus.f_req = 1'b0; #1;
        chk("none_maddr", bus.m_addr, 0);
        chk("none_wdata", bus.m_wdata, 0);
        chk("none_mwe", bus.m_we, 0);

        // Reset while a read is returning
        @(negedge clk);
        bus.f_req = 1'b1; bus.f_addr = 32'h10;
        @(negedge clk);
        bus.f_req = 1'b0;
        chk("rm_valid_pre", bus.f_valid, 1);
        rst = 1'b1; #1;
        chk("rm_valid", bus.f_valid, 0);
        chk("rm_inst", bus.f_inst, 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("rm_no_valid", bus.f_valid, 0);
        bus.f_req = 1'b1; bus.f_addr = 32'h14; #1;
        chk("rm_first_grant", bus.f_stall, 0);
        @(negedge clk);
        chk("rm_new_valid", bus.f_valid, 1);
        chk("rm_new_inst", bus.f_inst, 32'hA500_0005);
        bus.f_req = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pl_imem_arb.md
PL_IMEM_ARB -- requirements
Module: pl_imem_arb

Interface
REQ-001 Parameter AW, default 6, instruction-memory word-address width (64 words).
REQ-002 Parameter MAXWAIT, default 4, maximum consecutive loader grants while a fetch is pending.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 f_req  input  1  CPU fetch request, level, held until granted.
REQ-006 f_addr  input  32  CPU fetch byte address (pc).
REQ-007 f_stall  output  1  fetch requested but not granted this cycle; freezes pc/IF stage.
REQ-008 f_valid  output  1  f_inst holds data for the fetch granted in the previous cycle.
REQ-009 f_inst  output  32  fetched instruction word.
REQ-010 l_req  input  1  program-loader write request, level, held until acknowledged.
REQ-011 l_addr  input  32  loader byte address.
REQ-012 l_data  input  32  loader write data.
REQ-013 l_ack  output  1  loader write performed this cycle.
REQ-014 m_we  output  1  memory write enable.
REQ-015 m_addr  output  AW  memory word address.
REQ-016 m_wdata  output  32  memory write data.
REQ-017 m_rdata  input  32  memory read data, valid one cycle after m_addr presented with m_we=0.

Function
REQ-018 The block SHALL grant at most one memory access per cycle: fetch (F), load (L) or none.
REQ-019 Grant SHALL be combinational from f_req, l_req and registered state: only f_req -> F; only l_req -> L; both -> L unless starve count equals MAXWAIT, then F.
REQ-020 Starve count SHALL increment on each L grant while f_req=1, clear on any F grant or any cycle with f_req=0, and saturate at MAXWAIT.
REQ-021 On F grant: m_we=0, m_addr=f_addr[AW+1:2], f_stall=0.
REQ-022 On L grant: m_we=1, m_addr=l_addr[AW+1:2], m_wdata=l_data, l_ack=1 same cycle.
REQ-023 f_stall SHALL equal f_req AND NOT F-grant; l_ack SHALL be 0 when no L grant.
REQ-024 Address bits [1:0] and bits above AW+1 SHALL be ignored (word-aligned, wraps modulo 2^AW words).
REQ-025 A registered read-pending flag SHALL be set for the cycle after each F grant; in that cycle f_valid=1 and f_inst=m_rdata.
REQ-026 f_inst SHALL be registered-capture of m_rdata when pending and SHALL hold its last value otherwise; f_valid=0 when not pending.
REQ-027 Back-to-back F grants SHALL sustain one fetch per cycle (throughput 1, latency 1).
REQ-028 Fetch of a word written by an L grant in the previous cycle SHALL return the new data.
REQ-029 When neither request: m_we=0, m_addr=0, m_wdata=0.

Reset
REQ-030 While rst=1: f_valid=0, f_inst=0, l_ack=0, m_we=0, starve count=0, read-pending=0, independent of clk.
REQ-031 A read outstanding when rst asserts SHALL be discarded; no f_valid after rst deasserts.
REQ-032 First grant SHALL occur in the first clk edge after rst deasserts.

Verification
REQ-033 Fetch only: f_req=1, f_addr=0x00,0x04,0x08 consecutive -> f_valid=1 one cycle after each, f_inst = words 0,1,2; f_stall=0 throughout.
REQ-034 Load then fetch: l_req writes 0x3c010000 at 0x6c, next cycle fetch 0x6c -> l_ack=1 in write cycle, f_inst=0x3c010000 one cycle after fetch.
REQ-035 Contention: f_req and l_req both held 10 cycles, MAXWAIT=4 -> grants L,L,L,L,F,L,L,L,L,F; f_stall=1 exactly on L cycles.
REQ-036 Address wrap: fetch f_addr=0x104 with AW=6 -> m_addr=1; f_addr=0x07 -> m_addr=1.
REQ-037 Reset mid-read: rst asserted the cycle after F grant -> f_valid=0, f_inst=0 immediately; no f_valid after release until new F grant.
